// File: rtl/fft_out_serializer.sv
// fft_out_serializer: buffers NUM-lane parallel I/Q blocks in a block FIFO and streams
// them one sample per cycle, lane 0 first, on a valid/ready interface.
module fft_out_serializer #(
   parameter int WIDTH = 12,
   parameter int NUM   = 16,
   parameter int N     = 512,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [WIDTH*NUM-1:0]     din_i,
   input  logic [WIDTH*NUM-1:0]     din_q,
   output logic [WIDTH-1:0]         dout_i,
   output logic [WIDTH-1:0]         dout_q,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = NUM > 1 ? $clog2(NUM) : 1;
   localparam int BPF = N / NUM;
   localparam int BW  = BPF > 1 ? $clog2(BPF) : 1;

   logic [WIDTH*NUM-1:0] mem_i [DEPTH];
   logic [WIDTH*NUM-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [LW-1:0] lane_q, lane_d;
   logic [BW-1:0] blk_q, blk_d;
   logic          ovf_q, ovf_d;
   logic          pop, pop_blk, last_lane, wr;

   always_comb begin
      last_lane  = lane_q == LW'(NUM - 1);
      dout_valid = level_q != '0;
      pop        = dout_valid & dout_ready;
      pop_blk    = pop & last_lane;
      // a final-lane pop frees the head slot in the same edge, so a full FIFO can still accept
      wr         = valid_in & ((level_q != (AW+1)'(DEPTH)) | pop_blk);
      wr_ptr_d   = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop_blk ? rd_ptr_q + 1'b1 : rd_ptr_q;
      lane_d     = pop ? (last_lane ? '0 : lane_q + 1'b1) : lane_q;
      blk_d      = pop_blk ? (blk_q == BW'(BPF - 1) ? '0 : blk_q + 1'b1) : blk_q;
      level_d    = (wr & ~pop_blk) ? level_q + 1'b1 : ((~wr & pop_blk) ? level_q - 1'b1 : level_q);
      ovf_d      = ovf_q | (valid_in & ~wr);
      dout_i     = dout_valid ? mem_i[rd_ptr_q][int'(lane_q)*WIDTH +: WIDTH] : '0;
      dout_q     = dout_valid ? mem_q[rd_ptr_q][int'(lane_q)*WIDTH +: WIDTH] : '0;
      dout_last  = dout_valid & last_lane & (blk_q == BW'(BPF - 1));
      overflow   = ovf_q;
      level      = level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         lane_q   <= '0;
         blk_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         lane_q   <= lane_d;
         blk_q    <= blk_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_i[wr_ptr_q] <= din_i;
         mem_q[wr_ptr_q] <= din_q;
      end
   end
endmodule
